// File: rtl/hrm_mm_pkg.sv
// Shared definitions for the hot-redundancy MCU link receive memory manager.
// Provides the stream-word flag bit positions, the default storable type
// word, the writer FSM states and the read-bank selection encoding.
package hrm_mm_pkg;

  localparam logic [15:0] DATA_TYPE_DEF = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DROP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    BANK0   = 2'd0,
    BANK1   = 2'd1,
    RD_IDLE = 2'd2
  } rd_sel_t;

  // A stream word is DATA_W payload bits with EOP and SOP stacked above them.
  function automatic int sop_idx(input int dw);
    return dw + 1;
  endfunction

  function automatic int eop_idx(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/hrm_mmrx_bank.sv
// One ping-pong bank: simple dual-port RAM, one write port and one read port
// with a registered read (1-cycle latency). Contents are not reset.
// Ports:
//   clk_100m  - clock
//   we        - write enable
//   wr_addr   - write address (slot*SLOT_DEPTH + offset)
//   wr_data   - stream word to store (SOP/EOP/payload)
//   rd_addr   - read address
//   rd_q      - registered read data
module hrm_mmrx_bank #(
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              clk_100m,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W+1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W+1:0] rd_q
);

  logic [DATA_W+1:0] mem [2**AW];

  always_ff @(posedge clk_100m) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---- read stage boundary: address -> rd_q
  always_ff @(posedge clk_100m) begin
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/hrm_mmrx_pp.sv
// Receive-side memory manager for the hot-redundancy MCU link.
// Parses slink frames (SOP word carrying the destination, type word, payload)
// and stores DATA_TYPE payloads into per-destination slots of a ping-pong
// bank pair. The most recently completed bank is exposed to the EMIF port.
// Ports:
//   clk_100m, rst_100m      - clock, asynchronous active-low reset
//   chn_sel, hrm_pkt_num    - EMIF read-window start (rising chn_sel, pkt 0)
//   rd_addr, rd_data        - EMIF read port, 1-cycle latency
//   slink_mm_empty          - slink FIFO empty
//   mmrx_slink_rdreq        - FIFO read request (= !slink_mm_empty)
//   slink_mmrx_dval/_data   - stream word and its valid
//   mm_delay_err            - no bank completed within DLY_MAX cycles
//   mm_ovf_err              - pulse per payload word dropped on slot overflow
module hrm_mmrx_pp
  import hrm_mm_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                SLOT_NUM   = 4,
  parameter int                SLOT_DEPTH = 256,
  parameter logic [DATA_W-1:0] DATA_TYPE  = DATA_W'(DATA_TYPE_DEF),
  parameter logic [19:0]       DLY_MAX    = 20'd1000000,
  parameter int                AW         = $clog2(SLOT_NUM*SLOT_DEPTH)
) (
  input  logic              clk_100m,
  input  logic              rst_100m,
  input  logic              chn_sel,
  input  logic [3:0]        hrm_pkt_num,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W+1:0] rd_data,
  input  logic              slink_mm_empty,
  output logic              mmrx_slink_rdreq,
  input  logic              slink_mmrx_dval,
  input  logic [DATA_W+1:0] slink_mmrx_data,
  output logic              mm_delay_err,
  output logic              mm_ovf_err
);

  localparam int              SW        = $clog2(SLOT_NUM);
  localparam int              DW        = $clog2(SLOT_DEPTH);
  localparam int              OW        = DW + 1;
  localparam int              SOP_B     = sop_idx(DATA_W);
  localparam int              EOP_B     = eop_idx(DATA_W);
  localparam logic [7:0]      SLOT_LIM  = 8'(SLOT_NUM);
  localparam logic [7:0]      LAST_DEST = 8'(SLOT_NUM - 1);
  localparam logic [OW-1:0]   DEPTH_O   = OW'(SLOT_DEPTH);

  wr_state_t         state, state_nxt;
  logic [7:0]        dest;
  logic [OW-1:0]     offset;
  logic              wr_bank;
  logic [1:0]        full;
  rd_sel_t           rd_sel, rd_sel_p1, sel_nxt;
  logic              chn_sel_p1;
  logic [19:0]       dly_cnt;
  logic              w_sop, w_eop, hdr_ok;
  logic              wr_en, ovf_hit, bank_done, bank_clr, rd_start;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W+1:0] q0, q1;

  assign mmrx_slink_rdreq = !slink_mm_empty;

  assign w_sop   = slink_mmrx_data[SOP_B];
  assign w_eop   = slink_mmrx_data[EOP_B];
  assign hdr_ok  = (slink_mmrx_data[DATA_W-1:0] == DATA_TYPE) && (dest < SLOT_LIM);
  assign wr_addr = {dest[SW-1:0], offset[DW-1:0]};

  // Writer FSM: state register
  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Writer FSM: next state. A SOP anywhere restarts parsing; a SOP that
  // also carries EOP is an empty frame and leaves nothing to parse.
  always_comb begin
    state_nxt = state;
    if (slink_mmrx_dval) begin
      if (w_sop) begin
        state_nxt = w_eop ? ST_IDLE : ST_HDR;
      end else begin
        case (state)
          ST_IDLE: state_nxt = ST_IDLE;
          ST_HDR:  state_nxt = w_eop ? ST_IDLE : (hdr_ok ? ST_PAY : ST_DROP);
          ST_PAY:  state_nxt = w_eop ? ST_IDLE : ST_PAY;
          ST_DROP: state_nxt = w_eop ? ST_IDLE : ST_DROP;
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Writer FSM: outputs. Offset parks at SLOT_DEPTH once the slot is full,
  // so every further payload word of the frame is reported and dropped.
  always_comb begin
    wr_en   = 1'b0;
    ovf_hit = 1'b0;
    if (slink_mmrx_dval && !w_sop && (state == ST_PAY)) begin
      if (offset == DEPTH_O) begin
        ovf_hit = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end
    bank_done = wr_en && w_eop && (dest == LAST_DEST);
    bank_clr  = wr_en && (dest == 8'd0) && (offset == '0);
  end

  // Frame context (data path, not reset)
  always_ff @(posedge clk_100m) begin
    if (slink_mmrx_dval) begin
      if (w_sop) begin
        dest <= slink_mmrx_data[DATA_W-1 -: 8];
      end
      if ((state == ST_HDR) && (state_nxt == ST_PAY)) begin
        offset <= '0;
      end else if (wr_en) begin
        offset <= offset + OW'(1);
      end
    end
  end

  // Bank flags: a new dest-0 write means the bank is being refilled, so its
  // full flag drops; that clear takes priority over a completion.
  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      wr_bank    <= 1'b0;
      full       <= 2'b00;
      mm_ovf_err <= 1'b0;
      dly_cnt    <= '0;
    end else begin
      if (bank_clr) begin
        full[wr_bank] <= 1'b0;
      end else if (bank_done) begin
        full[wr_bank] <= 1'b1;
      end
      if (bank_done) begin
        wr_bank <= ~wr_bank;
      end
      mm_ovf_err <= ovf_hit;
      if (bank_done) begin
        dly_cnt <= '0;
      end else if (dly_cnt != DLY_MAX) begin
        dly_cnt <= dly_cnt + 20'd1;
      end
    end
  end

  assign mm_delay_err = (dly_cnt == DLY_MAX);

  hrm_mmrx_bank #(.DATA_W(DATA_W), .AW(AW)) u_bank0 (
    .clk_100m (clk_100m),
    .we       (wr_en & ~wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (slink_mmrx_data),
    .rd_addr  (rd_addr),
    .rd_q     (q0)
  );

  hrm_mmrx_bank #(.DATA_W(DATA_W), .AW(AW)) u_bank1 (
    .clk_100m (clk_100m),
    .we       (wr_en & wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (slink_mmrx_data),
    .rd_addr  (rd_addr),
    .rd_q     (q1)
  );

  assign rd_start = chn_sel && !chn_sel_p1 && (hrm_pkt_num == 4'd0);

  // With both banks complete the newer one is the one not being written.
  always_comb begin
    case (full)
      2'b11:   sel_nxt = wr_bank ? BANK0 : BANK1;
      2'b01:   sel_nxt = BANK0;
      2'b10:   sel_nxt = BANK1;
      default: sel_nxt = RD_IDLE;
    endcase
  end

  // ---- read stage boundary: selection follows the address into the RAM
  // register so rd_data always matches the bank chosen when it was addressed.
  always_ff @(posedge clk_100m or negedge rst_100m) begin
    if (!rst_100m) begin
      chn_sel_p1 <= 1'b0;
      rd_sel     <= RD_IDLE;
      rd_sel_p1  <= RD_IDLE;
    end else begin
      chn_sel_p1 <= chn_sel;
      if (rd_start) begin
        rd_sel <= sel_nxt;
      end
      rd_sel_p1 <= rd_sel;
    end
  end

  always_comb begin
    case (rd_sel_p1)
      BANK0:   rd_data = q0;
      BANK1:   rd_data = q1;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: doc/hrm_mmrx_pp.md
Name: hrm_mmrx_pp

Overview:
- Parametrised receive-side memory manager for the hot-redundancy MCU link.
- Parses slink frames (SOP word, type word, payload) and writes DATA_TYPE payloads into per-destination slots of a ping-pong pair of banks.
- Exposes the most recently completed bank to the EMIF read port.
- Adds what the previous generation lacks: configurable slot count/depth/width, slot overflow truncation, mid-frame abort on a new SOP, and a real frame-delay watchdog on mm_delay_err.

Parameters:
- DATA_W, 16, payload bits per word; a stream word is DATA_W+2 wide (bit DATA_W+1 = SOP, bit DATA_W = EOP).
- SLOT_NUM, 4, destination slots per bank; power of two, 2..16.
- SLOT_DEPTH, 256, words per slot; power of two.
- DATA_TYPE, 16'h0001, type-word value that enables storage.
- DLY_MAX, 20'd1000000, clk_100m cycles allowed between completed banks before mm_delay_err asserts.
- AW, log2(SLOT_NUM*SLOT_DEPTH), derived, read/write address width.

Ports:
- clk_100m, in, 1, 100 MHz clock.
- rst_100m, in, 1, reset, asynchronous, active-low.
- chn_sel, in, 1, EMIF channel select; rising edge is a read-window candidate.
- hrm_pkt_num, in, 4, EMIF packet index; 0 qualifies a read start.
- rd_addr, in, AW, EMIF read address: slot*SLOT_DEPTH + offset.
- rd_data, out, DATA_W+2, read word; 1-cycle latency.
- slink_mm_empty, in, 1, slink FIFO empty.
- mmrx_slink_rdreq, out, 1, equals !slink_mm_empty (combinational).
- slink_mmrx_dval, in, 1, stream word valid; arrives one cycle after rdreq.
- slink_mmrx_data, in, DATA_W+2, stream word.
- mm_delay_err, out, 1, watchdog: no bank completed within DLY_MAX cycles.
- mm_ovf_err, out, 1, one-cycle pulse when a payload word is dropped for slot overflow.

Behaviour:
- Reset values: rd_data=0, mm_delay_err=0, mm_ovf_err=0, wr_bank=0, both full flags=0, rd_sel=IDLE, FSM=IDLE.
- Writer FSM, all transitions on dval=1:
  - IDLE: SOP -> HDR; latch dest = data[DATA_W-1:DATA_W-8].
  - HDR: the next word is the type. If type==DATA_TYPE and dest<SLOT_NUM -> PAY with offset=0. Otherwise -> DROP.
  - PAY: write the word (including its EOP bit) at dest*SLOT_DEPTH+offset in bank wr_bank, then offset++. On EOP -> IDLE.
  - DROP: discard words until EOP -> IDLE.
- Slot overflow: when offset==SLOT_DEPTH, the word is not written, mm_ovf_err pulses, and the FSM stays in PAY until EOP. Offset never wraps.
- SOP seen in any state other than IDLE: abort the current frame without setting any flag, treat the word as a new SOP, and go to HDR.
- EOP on the SOP word (1-word frame): go to IDLE with no write.
- Bank completion: EOP written in PAY for dest==SLOT_NUM-1 sets full[wr_bank]=1 and toggles wr_bank on the next cycle.
- Bank clear: the first payload write of dest==0 clears full[wr_bank].
- Write and clear in the same cycle: clear wins.
- rd_start = rising edge of chn_sel (registered compare) AND hrm_pkt_num==0.
- rd_sel update on rd_start:
  - both flags set: select !wr_bank.
  - only full0 set: bank0.
  - only full1 set: bank1.
  - neither set: IDLE.
  - rd_sel holds between starts.
- rd_data (registered, 1 cycle after rd_addr) = selected bank's RAM output; 0 when rd_sel=IDLE.
- Read/write collision: the writer may overwrite the bank being read. No lock; software reads within one frame period.
- Watchdog: counter counts up and clears on every bank completion. When count reaches DLY_MAX, mm_delay_err=1 and the counter saturates. The next completion clears both.
- Reset mid-frame: FSM returns to IDLE and flags clear; RAM contents are undefined.

Decomposition:
- Package hrm_mm_pkg: SOP/EOP bit-index functions of DATA_W, DATA_TYPE default, writer FSM state enum, rd_sel encoding (BANK0, BANK1, IDLE).
- Sub-module hrm_mmrx_bank: simple dual-port RAM of SLOT_NUM*SLOT_DEPTH x (DATA_W+2), registered read. Instantiated twice; write enable gated by wr_bank.

Test Plan:
- Defaults. Frames dest=0..3, type=0x0001, 10 payload words each, then chn_sel rise with pkt_num=0 -> full0=1, wr_bank=1, rd_sel=BANK0; rd_addr=256 returns dest1 word0 one cycle later.
- Two full bank cycles, then a read start -> rd_sel = bank !wr_bank (the most recent completion); a read start with no completed bank -> rd_data=0.
- Type=0x0002 frame for dest=2 -> no RAM writes and no flag change; dest=5 (>=SLOT_NUM) -> dropped.
- Frame of 260 payload words to dest=1 -> exactly 4 mm_ovf_err pulses; words 0..255 stored; FSM returns to IDLE on EOP.
- SOP injected at payload word 5 of dest=3 -> no completion and full flags unchanged; the new frame is parsed normally.
- DLY_MAX=100, no traffic -> mm_delay_err=1 at cycle 100; one bank completion clears it. Async reset asserted mid-frame -> all outputs back to reset values immediately.
